serial_adder: RTL and testbench

Parametrised digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first, under a start/busy/done handshake. It replaces the single-bit combinational full adder with a reusable arithmetic engine for area-constrained datapaths, where one narrow adder is time-shared across a wide word. Result, carry-out and signed overflow are registered and held until the next operation completes.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_digit.sv | 30 +++
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// The state encoding and digit/counter sizing live here so the top and bench agree.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adderStateT;

    function automatic int numDigits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit word still needs a one-bit counter so the port widths stay legal.
    function automatic int counterWidth(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic carry;

    // The carry is a procedural variable so the ripple stays a single acyclic chain.
    always_comb begin
        s     = '0;
        co    = 1'b0;
        c_msb = 1'b0;
        carry = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-wide adder time-shared across a WIDTH-bit word,
// LSB first, with a start/busy/done handshake and held result registers.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG = numDigits(WIDTH, DIGIT);
    localparam int CNTW = counterWidth(WIDTH, DIGIT);
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
        $error("serial_adder: WIDTH must be >= 1 and an exact multiple of DIGIT");
    end

    adderStateT       state;
    adderStateT       stateNext;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic             carry;
    logic             accept;
    logic             lastDigit;

    logic [DIGIT-1:0] dSum;
    logic             dCarry;
    logic             dMsbCarry;
    logic [WIDTH-1:0] sumNext;

    digit_adder #(
        .DIGIT(DIGIT)
    ) uDigit (
        .a    (aSh[DIGIT-1:0]),
        .b    (bSh[DIGIT-1:0]),
        .ci   (carry),
        .s    (dSum),
        .co   (dCarry),
        .c_msb(dMsbCarry)
    );

    // Result digits enter from the MSB end; the lowest stored digit is dropped each
    // shift, so only WIDTH-DIGIT bits need holding between cycles.
    if (NDIG == 1) begin : gSingle
        assign sumNext = dSum;
    end else begin : gMulti
        logic [WIDTH-DIGIT-1:0] partial;

        assign sumNext = {dSum, partial};

        always_ff @(posedge clk) begin
            if (rst) begin
                partial <= '0;
            end else if (accept) begin
                partial <= '0;
            end else if (state == RUN) begin
                partial <= sumNext[WIDTH-1:DIGIT];
            end
        end
    end

    assign accept    = start && (state == IDLE || state == DONE);
    assign lastDigit = (state == RUN) && (cnt == LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Next-state logic; start is ignored while RUN so an operation can never be aborted.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (cnt == LAST) stateNext = DONE;
            DONE:    stateNext = start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and result registers; results change only on the final-digit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            aSh      <= '0;
            bSh      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                aSh   <= in_a;
                bSh   <= in_b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                aSh   <= aSh >> DIGIT;
                bSh   <= bSh >> DIGIT;
                carry <= dCarry;
                cnt   <= cnt + CNTW'(1);
            end
            if (lastDigit) begin
                sum      <= sumNext;
                cout     <= dCarry;
                overflow <= dCarry ^ dMsbCarry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder across several WIDTH/DIGIT shapes, with an
// exhaustive 4-bit sweep against an arithmetic reference.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start81 = 1'b0;
    logic       start84 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;

    logic       busy81, done81, cout81, ovf81;
    logic [7:0] sum81;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] sum84;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;

    logic       busy41, done41, cout41, ovf41;
    logic [3:0] sum41;
    logic       busy42, done42, cout42, ovf42;
    logic [3:0] sum42;

    int total = 0;
    int bad   = 0;
    logic bothHigh = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .rst(rst), .start(start81), .in_a(a8), .in_b(b8), .cin(cin8),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ovf81)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst(rst), .start(start84), .in_a(a8), .in_b(b8), .cin(cin8),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84)
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .rst(rst), .start(start4), .in_a(a4), .in_b(b4), .cin(cin4),
        .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .overflow(ovf41)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst(rst), .start(start4), .in_a(a4), .in_b(b4), .cin(cin4),
        .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .overflow(ovf42)
    );

    always @(negedge clk) begin
        if ((busy81 && done81) || (busy84 && done84) || (busy41 && done41) || (busy42 && done42))
            bothHigh <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts one op on an 8-bit DUT (sel=0: DIGIT=1, sel=1: DIGIT=4) and waits for done.
    task automatic applyStimulus(input logic sel, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, output int lat, output int busyN,
                                 output logic heldOk);
        logic [7:0] prev;
        prev   = sel ? sum84 : sum81;
        a8     = a;
        b8     = b;
        cin8   = c;
        if (sel) start84 = 1'b1; else start81 = 1'b1;
        tick();
        start81 = 1'b0;
        start84 = 1'b0;
        lat    = 0;
        busyN  = 0;
        heldOk = 1'b1;
        while (!(sel ? done84 : done81) && lat < 40) begin
            if (sel ? busy84 : busy81) busyN++;
            if ((sel ? sum84 : sum81) !== prev) heldOk = 1'b0;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busyN;
        int cyc;
        int doneCnt;
        logic heldOk;
        logic [4:0] ref5;
        logic [5:0] exp6;
        logic [5:0] res41;
        logic [5:0] res42;
        logic got41;
        logic got42;

        $display("[TB] serial_adder bench start");
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset81", 32'({busy81, done81, cout81, ovf81, sum81}), 32'h0);
        checkOutput("reset84", 32'({busy84, done84, cout84, ovf84, sum84}), 32'h0);
        rst = 1'b0;
        tick();

        applyStimulus(1'b0, 8'h3C, 8'h5A, 1'b0, lat, busyN, heldOk);
        checkOutput("lat_3c5a", 32'(lat), 32'd8);
        checkOutput("sum_3c5a", 32'(sum81), 32'h96);
        checkOutput("cout_3c5a", 32'(cout81), 32'h0);
        checkOutput("ovf_3c5a", 32'(ovf81), 32'h1);
        checkOutput("held_3c5a", 32'(heldOk), 32'h1);
        tick();
        checkOutput("donepulse_3c5a", 32'({busy81, done81}), 32'h0);

        applyStimulus(1'b0, 8'hFF, 8'h00, 1'b1, lat, busyN, heldOk);
        checkOutput("busyN_ff00", 32'(busyN), 32'd8);
        checkOutput("sum_ff00", 32'(sum81), 32'h00);
        checkOutput("cout_ff00", 32'(cout81), 32'h1);
        checkOutput("ovf_ff00", 32'(ovf81), 32'h0);
        tick();

        applyStimulus(1'b1, 8'h80, 8'h80, 1'b0, lat, busyN, heldOk);
        checkOutput("lat_8080", 32'(lat), 32'd2);
        checkOutput("sum_8080", 32'(sum84), 32'h00);
        checkOutput("cout_8080", 32'(cout84), 32'h1);
        checkOutput("ovf_8080", 32'(ovf84), 32'h1);
        applyStimulus(1'b1, 8'h01, 8'h02, 1'b0, lat, busyN, heldOk);
        checkOutput("lat_b2b", 32'(lat), 32'd2);
        checkOutput("held_b2b", 32'(heldOk), 32'h1);
        checkOutput("sum_b2b", 32'(sum84), 32'h03);
        checkOutput("cout_b2b", 32'(cout84), 32'h0);
        tick();

        // Mid-run start and operand churn must not disturb the op in flight.
        a8 = 8'h11;
        b8 = 8'h22;
        cin8 = 1'b0;
        start81 = 1'b1;
        tick();
        start81 = 1'b0;
        tick();
        tick();
        a8 = 8'hFF;
        b8 = 8'hFF;
        cin8 = 1'b1;
        start81 = 1'b1;
        tick();
        start81 = 1'b0;
        cyc = 3;
        while (!done81 && cyc < 40) begin
            a8 = ~a8;
            b8 = b8 ^ 8'h5A;
            tick();
            cyc++;
        end
        checkOutput("lat_ignore", 32'(cyc), 32'd8);
        checkOutput("sum_ignore", 32'(sum81), 32'h33);
        checkOutput("flags_ignore", 32'({cout81, ovf81}), 32'h0);
        tick();
        checkOutput("noqueue_ignore", 32'({busy81, done81}), 32'h0);

        // Reset in the middle of a run discards it without a done pulse.
        a8 = 8'h3C;
        b8 = 8'h5A;
        cin8 = 1'b0;
        start81 = 1'b1;
        tick();
        start81 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset", 32'({busy81, done81, cout81, ovf81, sum81}), 32'h0);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done81) doneCnt++;
            tick();
        end
        checkOutput("midreset_nodone", 32'(doneCnt), 32'd0);
        applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, lat, busyN, heldOk);
        checkOutput("lat_after_reset", 32'(lat), 32'd8);
        checkOutput("sum_after_reset", 32'(sum81), 32'h02);
        tick();

        // Exhaustive 4-bit sweep: both DUTs start together; each is captured on its done.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia);
                    b4 = 4'(ib);
                    cin4 = 1'(ic);
                    start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    got41 = 1'b0;
                    got42 = 1'b0;
                    res41 = '0;
                    res42 = '0;
                    cyc = 0;
                    while (!got41 && cyc < 20) begin
                        tick();
                        cyc++;
                        if (done42 && !got42) begin
                            got42 = 1'b1;
                            res42 = {cout42, ovf42, sum42};
                        end
                        if (done41) begin
                            got41 = 1'b1;
                            res41 = {cout41, ovf41, sum41};
                        end
                    end
                    ref5 = 5'(ia) + 5'(ib) + 5'(ic);
                    exp6 = {ref5[4], (a4[3] == b4[3]) && (ref5[3] != a4[3]), ref5[3:0]};
                    checkOutput($sformatf("w4d1_%0h_%0h_%0d", ia, ib, ic), 32'({got41, res41}), 32'({1'b1, exp6}));
                    checkOutput($sformatf("w4d2_%0h_%0h_%0d", ia, ib, ic), 32'({got42, res42}), 32'({1'b1, exp6}));
                end
            end
        end

        tick();
        checkOutput("busy_done_exclusive", 32'(bothHigh), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
